gonso_stepper_drv: RTL and testbench
====================================

// Module: gonso_stepper_drv
// PURPOSE
//  Downstream stage of the gonso core. Turns step commands (count, direction, period) into
//  coil phase patterns on io_out[35:32] (MOTOR outputs).
//  Tracks a signed position. Pulses the done flag that feeds irq[0].
// PARAMETERS
//  PSIZE   20  width of cmd_period_i / step-period timer (clocks per step)
//  SSIZE   16  width of cmd_steps_i / remaining-step counter and position counter
// PORTS
//  wb_clk_i       in   1      single clock; all logic posedge
//  wb_rst_i       in   1      reset, synchronous, active-high
//  cmd_valid_i    in   1      command offered
//  cmd_ready_o    out  1      command accepted when valid&&ready
//  cmd_steps_i    in   SSIZE  number of steps to issue (0 allowed)
//  cmd_dir_i      in   1      1 = forward (phase index +1), 0 = reverse (-1)
//  cmd_period_i   in   PSIZE  clocks between steps; values <2 treated as 2
//  cmd_hold_i     in   1      1 = keep coils energised after move, 0 = coast (phase 0000)
//  abort_i        in   1      stop current move
//  motor_phase_o  out  4      coil drive pattern -> io_out[35:32]
//  busy_o         out  1      move in progress
//  done_o         out  1      one-cycle pulse at end of move
//  aborted_o      out  1      sticky: last move ended by abort; cleared on next accept
//  position_o     out  SSIZE  signed step position, two's-complement wrap
// BEHAVIOUR
//  Reset values (sync, wb_rst_i=1): state IDLE, motor_phase_o 0000, phase index 0.
//   cmd_ready_o 0 while in reset. busy_o, done_o, aborted_o 0. position_o 0.
//  FSM states:
//   IDLE: cmd_ready_o=1.
//    On accept, latch steps/dir/hold and clamp+latch the period.
//    Timer <= period, aborted_o <= 0.
//    steps==0 -> DONE, else -> RUN.
//   RUN: busy_o=1, cmd_ready_o=0. Timer decrements each cycle.
//    At timer==1 (a step event):
//     - phase index +/-1 (mod 4 full-step, mod 8 half-step)
//     - position_o +/-1
//     - steps_left-1
//     - timer reloads to period
//    Last step (steps_left 1->0) -> DONE.
//   DONE: done_o=1 for exactly one cycle; busy_o=0. If hold==0, motor_phase_o <= 0000.
//    -> IDLE.
//  Timing:
//   - First step edge lands exactly `period` cycles after the accept edge.
//   - Later steps are spaced `period` cycles apart.
//   - A move of N steps returns to IDLE N*period+1 cycles after accept.
//  motor_phase_o is registered: table[index] while energised, 0000 when coasting.
//   On a new accept it resumes from the retained index (no phase jump).
//  Full-step table, idx 0..3: 0011, 0110, 1100, 1001.
//  abort_i in RUN -> DONE next edge, aborted_o=1, no further step.
//   Abort coinciding with a step event: abort wins, the step is NOT taken.
//   abort_i in IDLE/DONE: ignored.
//  cmd_valid_i while not ready: command held off; cmd_* must stay stable until accepted.
//  position_o wraps 0x7FFF -> 0x8000 forward and 0x8000 -> 0x7FFF reverse.
//  Reset mid-move: everything returns to reset values on the next edge; no done pulse.
// CONFIGURATION
//  GONSO_STEPPER_HALFSTEP_EN defined:
//   - 8-entry half-step table, idx 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001
//   - 3-bit phase index
//  Undefined: 4-entry full-step table, 2-bit index. Timing and position are identical;
//   one step = one table entry.
// STRUCTURE
//  Package gonso_stepper_pkg holds:
//   - FSM state encodings (IDLE/RUN/DONE)
//   - full- and half-step phase tables as constants
//   - PERIOD_MIN = 2
//  Sub-module gonso_step_timer (PSIZE down-counter):
//   - load, enable, tick (tick = timer==1)
//   - reload on tick
//  Top holds the FSM, step and position counters, and the phase table lookup.
// TESTING
//  1. Reset, then steps=4 dir=1 period=10 hold=1:
//     full-step phases 0110, 1100, 1001, 0011 at cycles 10, 20, 30, 40 after accept;
//     done_o pulses at cycle 41; position_o = 4.
//  2. steps=3 dir=0 period=5 hold=0 from idx 0:
//     phases 1001, 1100, 0110; position_o = -3 (0xFFFD);
//     motor_phase_o = 0000 after done.
//  3. period=0 and period=1, steps=2: both step every 2 cycles; done_o once.
//  4. steps=100 period=8; abort_i asserted on the same cycle as step #5:
//     position_o = 4, aborted_o = 1, done_o one pulse, cmd_ready_o = 1 next cycle.
//  5. steps=0: cmd_ready_o drops for 2 cycles; done_o pulses; phase and position unchanged.
//  6. position preset to 0x7FFF by a forward move, then 1 forward step: position_o = 0x8000.
//     Assert wb_rst_i mid-move: all outputs 0 next edge, no done.
//     Rerun test 1 with GONSO_STEPPER_HALFSTEP_EN: phases 0011, 0010, 0110, 0100.

Source files
------------

// File: rtl/gonso_stepper_pkg.sv
// rtl/gonso_stepper_pkg.sv - shared FSM encodings, coil phase tables and period floor for the stepper driver
package gonso_stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int PERIOD_MIN = 2;

  // Packed LSB-first: entry i lives at bits [4*i +: 4].
  localparam logic [15:0] FULL_TABLE = {4'b1001, 4'b1100, 4'b0110, 4'b0011};
  localparam logic [31:0] HALF_TABLE = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                        4'b0110, 4'b0010, 4'b0011, 4'b0001};

endpackage

// File: rtl/gonso_step_timer.sv
// rtl/gonso_step_timer.sv - step-period down-counter; tick when the count reaches 1, then reload
module gonso_step_timer #(
  parameter int PSIZE = 20
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             load,
  input  logic             enable,
  input  logic [PSIZE-1:0] load_val,
  output logic             tick
);

  logic [PSIZE-1:0] count;

  assign tick = (count == PSIZE'(1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable) begin
      if (tick) count <= load_val;
      else      count <= count - PSIZE'(1);
    end
  end

endmodule

// File: rtl/gonso_stepper_drv.sv
// rtl/gonso_stepper_drv.sv - step command FSM, position tracking and coil phase drive
// Optional GONSO_STEPPER_HALFSTEP_EN selects the 8-entry half-step table (3-bit phase index).
module gonso_stepper_drv
  import gonso_stepper_pkg::*;
#(
  parameter int PSIZE = 20,
  parameter int SSIZE = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [SSIZE-1:0] cmd_steps_i,
  input  logic             cmd_dir_i,
  input  logic [PSIZE-1:0] cmd_period_i,
  input  logic             cmd_hold_i,
  input  logic             abort_i,
  output logic [3:0]       motor_phase_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [SSIZE-1:0] position_o
);

`ifdef GONSO_STEPPER_HALFSTEP_EN
  localparam int IW = 3;
`else
  localparam int IW = 2;
`endif

  function automatic logic [3:0] phase_of(input logic [IW-1:0] i);
`ifdef GONSO_STEPPER_HALFSTEP_EN
    return HALF_TABLE[{i, 2'b00} +: 4];
`else
    return FULL_TABLE[{i, 2'b00} +: 4];
`endif
  endfunction

  state_t           state;
  logic [PSIZE-1:0] period_q;
  logic [PSIZE-1:0] period_clamped;
  logic [SSIZE-1:0] steps_left;
  logic             dir_q;
  logic             hold_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_next;
  logic             accept;
  logic             tick;

  assign period_clamped = (cmd_period_i < PSIZE'(PERIOD_MIN)) ? PSIZE'(PERIOD_MIN) : cmd_period_i;
  assign accept         = cmd_valid_i && cmd_ready_o;
  assign idx_next       = dir_q ? idx_q + IW'(1) : idx_q - IW'(1);

  // The accept edge loads the fresh clamped period; later reloads use the latched copy.
  gonso_step_timer #(.PSIZE(PSIZE)) u_timer (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .load     (accept),
    .enable   (state == ST_RUN),
    .load_val (accept ? period_clamped : period_q),
    .tick     (tick)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      cmd_ready_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      aborted_o     <= 1'b0;
      position_o    <= '0;
      motor_phase_o <= 4'b0000;
      idx_q         <= '0;
      steps_left    <= '0;
      period_q      <= '0;
      dir_q         <= 1'b0;
      hold_q        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready_o <= 1'b1;
          if (accept) begin
            cmd_ready_o   <= 1'b0;
            steps_left    <= cmd_steps_i;
            dir_q         <= cmd_dir_i;
            hold_q        <= cmd_hold_i;
            period_q      <= period_clamped;
            aborted_o     <= 1'b0;
            motor_phase_o <= phase_of(idx_q);
            if (cmd_steps_i == '0) begin
              state <= ST_DONE;
            end else begin
              state  <= ST_RUN;
              busy_o <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Abort takes priority over a coincident step event.
          if (abort_i) begin
            state     <= ST_DONE;
            busy_o    <= 1'b0;
            aborted_o <= 1'b1;
          end else if (tick) begin
            idx_q         <= idx_next;
            motor_phase_o <= phase_of(idx_next);
            position_o    <= dir_q ? position_o + SSIZE'(1) : position_o - SSIZE'(1);
            steps_left    <= steps_left - SSIZE'(1);
            if (steps_left == SSIZE'(1)) begin
              state  <= ST_DONE;
              busy_o <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          done_o <= 1'b1;
          if (!hold_q) motor_phase_o <= 4'b0000;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gonso_stepper_drv.sv
// tb/tb_gonso_stepper_drv.sv - scoreboard bench for gonso_stepper_drv (honours GONSO_STEPPER_HALFSTEP_EN)
module tb_gonso_stepper_drv;

  localparam int PSIZE = 20;
  localparam int SSIZE = 16;
`ifdef GONSO_STEPPER_HALFSTEP_EN
  localparam int NPH = 8;
`else
  localparam int NPH = 4;
`endif
  localparam int K_PHASE = 0;
  localparam int K_DONE  = 1;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [SSIZE-1:0] cmd_steps_i = '0;
  logic             cmd_dir_i = 1'b0;
  logic [PSIZE-1:0] cmd_period_i = '0;
  logic             cmd_hold_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [3:0]       motor_phase_o;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  logic [SSIZE-1:0] position_o;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          m_idx = 0;
  logic [15:0] m_pos = '0;

  gonso_stepper_drv #(.PSIZE(PSIZE), .SSIZE(SSIZE)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_steps_i   (cmd_steps_i),
    .cmd_dir_i     (cmd_dir_i),
    .cmd_period_i  (cmd_period_i),
    .cmd_hold_i    (cmd_hold_i),
    .abort_i       (abort_i),
    .motor_phase_o (motor_phase_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .aborted_o     (aborted_o),
    .position_o    (position_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [3:0] tbl(input int i);
`ifdef GONSO_STEPPER_HALFSTEP_EN
    case (i % 8)
      0: return 4'b0001;  1: return 4'b0011;  2: return 4'b0010;  3: return 4'b0110;
      4: return 4'b0100;  5: return 4'b1100;  6: return 4'b1000;  default: return 4'b1001;
    endcase
`else
    case (i % 4)
      0: return 4'b0011;  1: return 4'b0110;  2: return 4'b1100;  default: return 4'b1001;
    endcase
`endif
  endfunction

  // Accept edge is cycle 0; observations are taken at the negedge following edge k.
  task automatic run_move(input int steps, input bit dir, input int period, input bit hold,
                          input int abort_step, input string name);
    int   eff, ntaken, last, w, done_cnt;
    exp_t e;
    eff    = (period < 2) ? 2 : period;
    ntaken = (abort_step > 0) ? abort_step - 1 : steps;
    last   = (abort_step > 0) ? abort_step * eff : steps * eff;
    w = 0;
    while (cmd_ready_o !== 1'b1 && w < 100) begin
      @(negedge wb_clk_i);
      w++;
    end
    vectors++;
    if (cmd_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_wait: cmd_ready_o=%b required 1", name, cmd_ready_o);
    end
    cmd_steps_i  = SSIZE'(steps);
    cmd_dir_i    = dir;
    cmd_period_i = PSIZE'(period);
    cmd_hold_i   = hold;
    cmd_valid_i  = 1'b1;
    exp_q.push_back('{0, K_PHASE, 16'(tbl(m_idx))});
    for (int i = 1; i <= ntaken; i++) begin
      m_idx = dir ? (m_idx + 1) % NPH : (m_idx + NPH - 1) % NPH;
      m_pos = dir ? m_pos + 16'd1 : m_pos - 16'd1;
      exp_q.push_back('{i * eff, K_PHASE, 16'(tbl(m_idx))});
    end
    exp_q.push_back('{last + 1, K_DONE, 16'd1});
    if (!hold) exp_q.push_back('{last + 1, K_PHASE, 16'd0});
    done_cnt = 0;
    @(posedge wb_clk_i);
    for (int k = 0; k <= last + 2; k++) begin
      @(negedge wb_clk_i);
      if (k == 0) cmd_valid_i = 1'b0;
      abort_i = (abort_step > 0) && (k == last - 1);
      while (exp_q.size() > 0 && exp_q[0].cyc == k) begin
        e = exp_q.pop_front();
        vectors++;
        if (e.kind == K_PHASE && motor_phase_o !== e.val[3:0]) begin
          miscompares++;
          $display("FAIL %s phase@%0d: got %b required %b", name, k, motor_phase_o, e.val[3:0]);
        end
        if (e.kind == K_DONE && done_o !== 1'b1) begin
          miscompares++;
          $display("FAIL %s done@%0d: got %b required 1", name, k, done_o);
        end
      end
      if (done_o === 1'b1) done_cnt++;
      if (k == 0) begin
        vectors++;
        if (busy_o !== (steps > 0) || aborted_o !== 1'b0) begin
          miscompares++;
          $display("FAIL %s accept: busy=%b aborted=%b required %b 0", name, busy_o, aborted_o, steps > 0);
        end
      end
      if (k == last + 1) begin
        vectors++;
        if (cmd_ready_o !== 1'b0) begin
          miscompares++;
          $display("FAIL %s ready@done: got %b required 0", name, cmd_ready_o);
        end
      end
      if (k == last + 2) begin
        vectors++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
          miscompares++;
          $display("FAIL %s idle: ready=%b busy=%b required 1 0", name, cmd_ready_o, busy_o);
        end
      end
    end
    abort_i = 1'b0;
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
    end
    vectors++;
    if (position_o !== m_pos) begin
      miscompares++;
      $display("FAIL %s position: got %h required %h", name, position_o, m_pos);
    end
    vectors++;
    if (aborted_o !== (abort_step > 0)) begin
      miscompares++;
      $display("FAIL %s aborted: got %b required %b", name, aborted_o, abort_step > 0);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s scoreboard: %0d entries left required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    vectors++;
    if ({cmd_ready_o, busy_o, done_o, aborted_o, motor_phase_o, position_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: ready=%b busy=%b done=%b aborted=%b phase=%b pos=%h required all 0",
               cmd_ready_o, busy_o, done_o, aborted_o, motor_phase_o, position_o);
    end
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    vectors++;
    if (cmd_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b required 1", cmd_ready_o);
    end
    m_idx = 0;
    m_pos = '0;
  endtask

  task automatic test_full_move();
    run_move(4, 1'b1, 10, 1'b1, 0, "fwd4_p10_hold");
  endtask

  task automatic test_reverse_coast();
    run_move(3, 1'b0, 5, 1'b0, 0, "rev3_p5_coast");
  endtask

  task automatic test_period_clamp();
    run_move(2, 1'b1, 0, 1'b1, 0, "period0");
    run_move(2, 1'b1, 1, 1'b1, 0, "period1");
  endtask

  task automatic test_abort();
    run_move(100, 1'b1, 8, 1'b1, 5, "abort_at_step5");
  endtask

  task automatic test_zero_steps();
    run_move(0, 1'b1, 7, 1'b1, 0, "zero_steps");
  endtask

  task automatic test_wrap();
    logic [15:0] to_max;
    to_max = 16'h7FFF - m_pos;
    run_move(int'(to_max), 1'b1, 2, 1'b1, 0, "preset_7fff");
    run_move(1, 1'b1, 3, 1'b1, 0, "wrap_fwd");
    run_move(1, 1'b0, 3, 1'b1, 0, "wrap_rev");
  endtask

  task automatic test_reset_mid_move();
    int dones;
    cmd_steps_i  = 16'd10;
    cmd_dir_i    = 1'b1;
    cmd_period_i = 20'd4;
    cmd_hold_i   = 1'b1;
    cmd_valid_i  = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid_i = 1'b0;
    repeat (6) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    vectors++;
    if ({cmd_ready_o, busy_o, done_o, aborted_o, motor_phase_o, position_o} !== '0) begin
      miscompares++;
      $display("FAIL midmove_reset: ready=%b busy=%b done=%b aborted=%b phase=%b pos=%h required all 0",
               cmd_ready_o, busy_o, done_o, aborted_o, motor_phase_o, position_o);
    end
    wb_rst_i = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge wb_clk_i);
      if (done_o === 1'b1 || busy_o === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL midmove_no_done: %0d cycles with done/busy required 0", dones);
    end
    m_idx = 0;
    m_pos = '0;
  endtask

  task automatic test_back_to_back();
    run_move(4, 1'b1, 10, 1'b1, 0, "after_reset_fwd4");
    run_move(2, 1'b0, 3, 1'b1, 0, "b2b_rev2");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_move();
    test_reverse_coast();
    test_period_clamp();
    test_abort();
    test_zero_steps();
    test_wrap();
    test_reset_mid_move();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
